shapool_sequencer: RTL and testbench

Run-control sequencer for the shapool hashing pool. It loads a job into the pool and steps the 64-round SHA-256 schedule. It sweeps the per-device nonce range and qualifies the pool's difficulty match against double-hash pipeline fill. It latches the winning nonce and raises done/success toward the daisy chain and the result shift-out logic.

---
 rtl/shapool_sequencer.sv | 153 +++++++++++++++
 tb/tb_shapool_sequencer.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/shapool_sequencer.sv
// Purpose : run-control sequencer for the shapool hashing pool (job load, round stepping,
//           nonce sweep, fill-qualified match check, winning nonce latch, done/success).
// Latency : job_valid -> pool_load next cycle -> RUN the cycle after; done_in -> done_out one edge.
// Backpr. : none; the pool is free-running once in RUN, clear releases SUCCESS/DONE.
//
// Ports:
//   i_clk, i_reset_n      clock, asynchronous active-low reset
//   i_job_valid           job parameters and nonce start byte are stable
//   i_clear               return from SUCCESS/DONE to IDLE
//   i_nonce_start[7:0]    device nonce MSB byte
//   i_match               OR of pool match flags for the hash completing this cycle
//   i_done_in             upstream device finished (abort, see macro below)
//   o_pool_load           one-cycle load pulse
//   o_pool_run            pool advances one round per cycle
//   o_round               current round index
//   o_nonce               {nonce_start, sweep_cnt} entering the pool
//   o_result_nonce        nonce of the matching attempt
//   o_success, o_done_out terminal status toward the daisy chain
//
// Build option: define SHAPOOL_DAISY_ABORT_EN to let done_in abort a running sweep.
module shapool_sequencer #(
   parameter int ROUNDS      = 64,
   parameter int ROUND_WIDTH = 6,
   parameter int SWEEP_WIDTH = 24,
   parameter int NW          = 8 + SWEEP_WIDTH
) (
   input  logic                   i_clk,
   input  logic                   i_reset_n,
   input  logic                   i_job_valid,
   input  logic                   i_clear,
   input  logic [7:0]             i_nonce_start,
   input  logic                   i_match,
   input  logic                   i_done_in,
   output logic                   o_pool_load,
   output logic                   o_pool_run,
   output logic [ROUND_WIDTH-1:0] o_round,
   output logic [NW-1:0]          o_nonce,
   output logic [NW-1:0]          o_result_nonce,
   output logic                   o_success,
   output logic                   o_done_out
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_RUN,
      S_SUCCESS,
      S_DONE
   } state_t;

   state_t                 r_state;
   state_t                 w_state_nxt;
   logic [ROUND_WIDTH-1:0] r_round;
   logic [SWEEP_WIDTH-1:0] r_sweep;
   logic [1:0]             r_fill;
   logic [7:0]             r_nonce_start;
   logic [NW-1:0]          r_result_nonce;

   logic                   w_wrap;
   logic                   w_qual;
   logic                   w_hit;
   logic                   w_exhaust;
   logic                   w_abort;
   logic [SWEEP_WIDTH-1:0] w_k;

   // The hash completing now belongs to the attempt two passes behind the
   // one entering the pool (double-hash pipeline depth).
   assign w_k       = r_sweep - SWEEP_WIDTH'(2);
   assign w_wrap    = (r_state == S_RUN) && (r_round == ROUND_WIDTH'(ROUNDS - 1));
   assign w_qual    = w_wrap && (r_fill == 2'd2);
   assign w_hit     = w_qual && i_match;
   assign w_exhaust = w_qual && !i_match && (&w_k);

`ifdef SHAPOOL_DAISY_ABORT_EN
   assign w_abort = i_done_in;
`else
   logic w_unused_done_in;
   assign w_unused_done_in = i_done_in;
   assign w_abort          = 1'b0;
`endif

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Priority: qualified match > exhaustion > upstream abort.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:    if (i_job_valid) w_state_nxt = S_LOAD;
         S_LOAD:    w_state_nxt = S_RUN;
         S_RUN: begin
            if (w_hit)          w_state_nxt = S_SUCCESS;
            else if (w_exhaust) w_state_nxt = S_DONE;
            else if (w_abort)   w_state_nxt = S_DONE;
         end
         S_SUCCESS: if (i_clear) w_state_nxt = S_IDLE;
         S_DONE:    if (i_clear) w_state_nxt = S_IDLE;
         default:   w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_round        <= '0;
         r_sweep        <= '0;
         r_fill         <= '0;
         r_nonce_start  <= '0;
         r_result_nonce <= '0;
      end else begin
         case (r_state)
            S_LOAD: begin
               r_nonce_start <= i_nonce_start;
               r_round       <= '0;
               r_sweep       <= '0;
               r_fill        <= '0;
            end
            S_RUN: begin
               if (w_wrap) begin
                  r_round <= '0;
                  // The sweep counter freezes on the edge that leaves RUN so
                  // o_nonce keeps showing the last attempt entered.
                  if (w_state_nxt == S_RUN) begin
                     r_sweep <= r_sweep + SWEEP_WIDTH'(1);
                  end
                  if (r_fill != 2'd2) begin
                     r_fill <= r_fill + 2'd1;
                  end
               end else begin
                  r_round <= r_round + ROUND_WIDTH'(1);
               end
               if (w_hit) begin
                  r_result_nonce <= {r_nonce_start, w_k};
               end
            end
            default: ;
         endcase
      end
   end

   assign o_pool_load    = (r_state == S_LOAD);
   assign o_pool_run     = (r_state == S_RUN);
   assign o_success      = (r_state == S_SUCCESS);
   assign o_done_out     = (r_state == S_SUCCESS) || (r_state == S_DONE);
   assign o_round        = r_round;
   assign o_nonce        = {r_nonce_start, r_sweep};
   assign o_result_nonce = r_result_nonce;

endmodule

// File: tb/tb_shapool_sequencer.sv
// Purpose : directed check of shapool_sequencer with ROUNDS=64, SWEEP_WIDTH=2.
// Latency : expected values hand-computed from RUN-edge counts after LOAD.
// Backpr. : n/a.
module tb_shapool_sequencer;

   localparam int ROUNDS = 64;
   localparam int RW     = 6;
   localparam int SW     = 2;
   localparam int NW     = 8 + SW;

   logic          clk;
   logic          reset_n;
   logic          job_valid;
   logic          clear;
   logic [7:0]    nonce_start;
   logic          match;
   logic          done_in;
   logic          pool_load;
   logic          pool_run;
   logic [RW-1:0] round;
   logic [NW-1:0] nonce;
   logic [NW-1:0] result_nonce;
   logic          success;
   logic          done_out;

   int n_chk;
   int n_pass;

   shapool_sequencer #(
      .ROUNDS      (ROUNDS),
      .ROUND_WIDTH (RW),
      .SWEEP_WIDTH (SW)
   ) u_dut (
      .i_clk          (clk),
      .i_reset_n      (reset_n),
      .i_job_valid    (job_valid),
      .i_clear        (clear),
      .i_nonce_start  (nonce_start),
      .i_match        (match),
      .i_done_in      (done_in),
      .o_pool_load    (pool_load),
      .o_pool_run     (pool_run),
      .o_round        (round),
      .o_nonce        (nonce),
      .o_result_nonce (result_nonce),
      .o_success      (success),
      .o_done_out     (done_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, ".load"},  32'(pool_load),    32'd0);
      chk({tag, ".run"},   32'(pool_run),     32'd0);
      chk({tag, ".round"}, 32'(round),        32'd0);
      chk({tag, ".nonce"}, 32'(nonce),        32'd0);
      chk({tag, ".res"},   32'(result_nonce), 32'd0);
      chk({tag, ".succ"},  32'(success),      32'd0);
      chk({tag, ".done"},  32'(done_out),     32'd0);
   endtask

   // job_valid at edge E0 -> LOAD; edge E1 -> RUN with round 0.
   task automatic start_job(input string tag);
      job_valid = 1'b1;
      tick(1);
      chk({tag, ".pool_load"}, 32'(pool_load), 32'd1);
      job_valid = 1'b0;
      tick(1);
      chk({tag, ".pool_run"}, 32'(pool_run), 32'd1);
      chk({tag, ".round0"},   32'(round),    32'd0);
   endtask

   task automatic pulse_reset();
      reset_n = 1'b0;
      #1;
      chk_all_zero("rst");
      tick(2);
      reset_n = 1'b1;
      tick(1);
   endtask

   initial begin
      n_chk       = 0;
      n_pass      = 0;
      reset_n     = 1'b0;
      job_valid   = 1'b0;
      clear       = 1'b0;
      nonce_start = 8'h00;
      match       = 1'b0;
      done_in     = 1'b0;
      #2;
      chk_all_zero("reset");
      tick(2);
      reset_n = 1'b1;
      tick(1);
      chk_all_zero("idle");

      // Match only at the wrap that checks k=0: RUN edge 192.
      start_job("j1");
      tick(191);
      chk("j1.round63", 32'(round), 32'd63);
      chk("j1.nonce",   32'(nonce), 32'h002);
      chk("j1.nosucc",  32'(success), 32'd0);
      match = 1'b1;
      tick(1);
      match = 1'b0;
      chk("j1.success", 32'(success),      32'd1);
      chk("j1.done",    32'(done_out),     32'd1);
      chk("j1.res",     32'(result_nonce), 32'h000);
      chk("j1.runoff",  32'(pool_run),     32'd0);
      tick(5);
      chk("j1.hold",    32'(success), 32'd1);
      chk("j1.rhold",   32'(round),   32'd0);

      // job_valid ignored in SUCCESS; clear returns to IDLE.
      job_valid = 1'b1;
      tick(1);
      chk("sx.noload", 32'(pool_load), 32'd0);
      chk("sx.succ",   32'(success),   32'd1);
      job_valid = 1'b0;
      clear     = 1'b1;
      tick(1);
      clear = 1'b0;
      chk("sx.idle", 32'(done_out),  32'd0);
      chk("sx.nold", 32'(pool_load), 32'd0);

      // Match during passes 0-1 is ignored; never match after -> exhaustion.
      nonce_start = 8'hA5;
      start_job("j2");
      match = 1'b1;
      tick(128);
      match = 1'b0;
      chk("j2.ignored", 32'(success),  32'd0);
      chk("j2.running", 32'(pool_run), 32'd1);
      tick(255);
      chk("j2.predone",  32'(done_out), 32'd0);
      chk("j2.preround", 32'(round),    32'd63);
      tick(1);
      chk("j2.done",   32'(done_out),     32'd1);
      chk("j2.succ",   32'(success),      32'd0);
      chk("j2.res",    32'(result_nonce), 32'h000);
      chk("j2.round",  32'(round),        32'd0);
      chk("j2.nonce",  32'(nonce),        32'h295);
      tick(3);
      chk("j2.nhold",  32'(nonce),        32'h295);
      clear = 1'b1;
      tick(1);
      clear = 1'b0;
      chk("j2.idle", 32'(done_out), 32'd0);

      // Upstream abort at round 17.
      start_job("j3");
      tick(17);
      chk("j3.round17", 32'(round), 32'd17);
      done_in = 1'b1;
      tick(1);
      done_in = 1'b0;
`ifdef SHAPOOL_DAISY_ABORT_EN
      chk("j3.done", 32'(done_out), 32'd1);
      chk("j3.succ", 32'(success),  32'd0);
      chk("j3.run",  32'(pool_run), 32'd0);
      clear = 1'b1;
      tick(1);
      clear = 1'b0;
`else
      chk("j3.done",  32'(done_out), 32'd0);
      chk("j3.run",   32'(pool_run), 32'd1);
      chk("j3.round", 32'(round),    32'd18);
      pulse_reset();
`endif
      chk("j3.idle", 32'(done_out), 32'd0);

      // Qualified match and done_in on the same edge -> SUCCESS with k=0.
      start_job("j4");
      tick(191);
      match   = 1'b1;
      done_in = 1'b1;
      tick(1);
      match   = 1'b0;
      done_in = 1'b0;
      chk("j4.success", 32'(success),      32'd1);
      chk("j4.res",     32'(result_nonce), 32'h294);
      clear = 1'b1;
      tick(1);
      clear = 1'b0;

      // Asynchronous reset mid-RUN, then a fresh job restarts the sweep.
      start_job("j5");
      tick(40 + 64);
      chk("j5.round40", 32'(round), 32'd40);
      chk("j5.nonce",   32'(nonce), 32'h295);
      pulse_reset();
      chk("j5.idle",    32'(pool_run), 32'd0);
      start_job("j6");
      chk("j6.nonce0", 32'(nonce), 32'h294);
      tick(64);
      chk("j6.nonce1", 32'(nonce), 32'h295);
      chk("j6.round",  32'(round), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
